bin_list_walker: RTL and testbench

BIN_LIST_WALKER -- requirements
Module: bin_list_walker

---
 rtl/bin_list_walker_if.sv | 35 +++
 rtl/bin_list_walker.sv | 140 ++++++++++++++
 tb/tb_bin_list_walker.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bin_list_walker_if.sv
// Bundle of walk request, bin list heads, geometry memory and triangle stream signals.
// master = the walker itself, slave = the surrounding binning/raster logic.
interface bin_list_walker_if #(
    parameter int binBits      = 4,
    parameter int numBinsSideX = 8,
    parameter int numBinsSideY = 8
);
    logic                                           startWalk;
    logic [binBits-1:0]                             binX;
    logic [binBits-1:0]                             binY;
    logic                                           doneBinning;
    logic [numBinsSideX-1:0][numBinsSideY-1:0][11:0] listRegisters;
    logic [11:0]                                    binMemoryReadAddress;
    logic [143:0]                                   binMemoryQ;
    logic [131:0]                                   triData;
    logic                                           triValid;
    logic                                           triReady;
    logic                                           binBusy;
    logic                                           binDone;
    logic                                           walkAborted;
    logic                                           walkError;
    logic [11:0]                                    triCount;

    modport master (
        input  startWalk, binX, binY, doneBinning, listRegisters, binMemoryQ, triReady,
        output binMemoryReadAddress, triData, triValid, binBusy, binDone,
               walkAborted, walkError, triCount
    );

    modport slave (
        output startWalk, binX, binY, doneBinning, listRegisters, binMemoryQ, triReady,
        input  binMemoryReadAddress, triData, triValid, binBusy, binDone,
               walkAborted, walkError, triCount
    );
endinterface

// File: rtl/bin_list_walker.sv
// Walks the linked list of triangles stored for one screen bin and streams each
// triangle record out over a valid/ready handshake.
module bin_list_walker #(
    parameter int binBits      = 4,
    parameter int numBinsSideX = 8,
    parameter int numBinsSideY = 8
) (
    input logic                   BOARD_CLK,
    input logic                   RESET_N,
    bin_list_walker_if.master     walkBus
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        PRESENT,
        DONE
    } walkState_t;

    // Reaching this count on a handshake means the list is almost certainly cyclic.
    localparam logic [11:0] GUARD_LAST = 12'd4094;

    walkState_t   r_state;
    logic [11:0]  r_readAddr;
    logic [11:0]  r_nextPtr;
    logic [131:0] r_triData;
    logic         r_triValid;
    logic         r_binBusy;
    logic         r_binDone;
    logic         r_walkAborted;
    logic         r_walkError;
    logic [11:0]  r_triCount;

    logic [11:0]  w_headAddr;
    logic         w_handshake;
    logic         w_abort;

    // Out-of-range coordinates fall through to the default and read as an empty bin.
    always_comb begin
        w_headAddr = '0;
        for (int x = 0; x < numBinsSideX; x++) begin
            for (int y = 0; y < numBinsSideY; y++) begin
                if (walkBus.binX == binBits'(x) && walkBus.binY == binBits'(y)) begin
                    w_headAddr = walkBus.listRegisters[x][y];
                end
            end
        end
    end

    assign w_handshake = (r_state == PRESENT) && walkBus.triReady;
    assign w_abort     = r_binBusy && !walkBus.doneBinning;

    always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state       <= IDLE;
            r_readAddr    <= '0;
            r_nextPtr     <= '0;
            r_triData     <= '0;
            r_triValid    <= 1'b0;
            r_binBusy     <= 1'b0;
            r_binDone     <= 1'b0;
            r_walkAborted <= 1'b0;
            r_walkError   <= 1'b0;
            r_triCount    <= '0;
        end else begin
            r_binDone     <= 1'b0;
            r_walkAborted <= 1'b0;

            // A handshake still counts when an abort lands on the same edge.
            if (w_handshake) begin
                r_triCount <= r_triCount + 12'd1;
            end

            if (w_abort) begin
                r_state       <= IDLE;
                r_triValid    <= 1'b0;
                r_binBusy     <= 1'b0;
                r_walkAborted <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (walkBus.startWalk && walkBus.doneBinning) begin
                            r_triCount  <= '0;
                            r_walkError <= 1'b0;
                            r_binBusy   <= 1'b1;
                            if (w_headAddr == 12'd0) begin
                                r_state <= DONE;
                            end else begin
                                r_readAddr <= w_headAddr;
                                r_state    <= READ;
                            end
                        end
                    end
                    READ: begin
                        r_state <= LATCH;
                    end
                    LATCH: begin
                        r_triData  <= walkBus.binMemoryQ[131:0];
                        r_nextPtr  <= walkBus.binMemoryQ[143:132];
                        r_triValid <= 1'b1;
                        r_state    <= PRESENT;
                    end
                    PRESENT: begin
                        if (walkBus.triReady) begin
                            r_triValid <= 1'b0;
                            if (r_triCount == GUARD_LAST) begin
                                r_walkError <= 1'b1;
                                r_state     <= DONE;
                            end else if (r_nextPtr == 12'd0) begin
                                r_state <= DONE;
                            end else begin
                                r_readAddr <= r_nextPtr;
                                r_state    <= READ;
                            end
                        end
                    end
                    DONE: begin
                        r_binDone <= 1'b1;
                        r_binBusy <= 1'b0;
                        r_state   <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign walkBus.binMemoryReadAddress = r_readAddr;
    assign walkBus.triData              = r_triData;
    assign walkBus.triValid             = r_triValid;
    assign walkBus.binBusy              = r_binBusy;
    assign walkBus.binDone              = r_binDone;
    assign walkBus.walkAborted          = r_walkAborted;
    assign walkBus.walkError            = r_walkError;
    assign walkBus.triCount             = r_triCount;

endmodule

// File: tb/tb_bin_list_walker.sv
// Scoreboard bench for bin_list_walker: directed walks push expected triangle
// records, a negedge monitor pops and compares every accepted triangle.
module tb_bin_list_walker;

    logic BOARD_CLK = 1'b0;
    logic RESET_N   = 1'b0;

    bin_list_walker_if #(.binBits(4), .numBinsSideX(8), .numBinsSideY(8)) bus ();

    bin_list_walker #(.binBits(4), .numBinsSideX(8), .numBinsSideY(8)) dut (
        .BOARD_CLK (BOARD_CLK),
        .RESET_N   (RESET_N),
        .walkBus   (bus.master)
    );

    always #5 BOARD_CLK = ~BOARD_CLK;

    int vecCount  = 0;
    int missCount = 0;
    int hsCount   = 0;
    logic [131:0] expQ [$];

    logic [143:0] mem [4096];

    // Synchronous-read geometry memory: data appears one edge after the address.
    always @(posedge BOARD_CLK) begin
        bus.binMemoryQ <= mem[bus.binMemoryReadAddress];
    end

    function automatic logic [131:0] triRec(input logic [11:0] a);
        return {a, 8'hA5, {7{a, 4'h3}}};
    endfunction

    task automatic checkOutput(input string name, input logic [143:0] actual,
                               input logic [143:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor plus hold-stability check under backpressure.
    logic         prevValid = 1'b0;
    logic         prevReady = 1'b0;
    logic [131:0] prevData  = '0;

    always @(negedge BOARD_CLK) begin
        if (RESET_N) begin
            if (prevValid && !prevReady && bus.triValid) begin
                checkOutput("heldData", bus.triData, prevData);
            end
            if (bus.triValid && bus.triReady) begin
                hsCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedTri", 144'd1, 144'd0);
                end else begin
                    checkOutput("triData", bus.triData, expQ.pop_front());
                end
            end
            prevValid <= bus.triValid;
            prevReady <= bus.triReady;
            prevData  <= bus.triData;
        end else begin
            prevValid <= 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle;
        @(posedge BOARD_CLK);
        #1;
    endtask

    task automatic sample;
        @(negedge BOARD_CLK);
    endtask

    // Presents a start request; returns one time unit after the accepting edge.
    task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y);
        bus.binX      = x;
        bus.binY      = y;
        bus.startWalk = 1'b1;
        @(posedge BOARD_CLK);
        #1;
        bus.startWalk = 1'b0;
    endtask

    task automatic walkThree(input string tag);
        expQ.push_back(triRec(12'd5));
        expQ.push_back(triRec(12'd9));
        expQ.push_back(triRec(12'd7));
        bus.triReady = 1'b1;
        applyStimulus(4'd1, 4'd2);
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) nextCycle();
            sample();
            checkOutput($sformatf("%s.triValid@%0d", tag, c), 144'(bus.triValid),
                        144'(c == 3 || c == 6 || c == 9));
            checkOutput($sformatf("%s.binDone@%0d", tag, c), 144'(bus.binDone), 144'(c == 11));
            if (c == 1) checkOutput({tag, ".readAddr"}, 144'(bus.binMemoryReadAddress), 144'd5);
            if (c == 11) checkOutput({tag, ".triCount"}, 144'(bus.triCount), 144'd3);
            if (c == 12) checkOutput({tag, ".busyAfter"}, 144'(bus.binBusy), 144'd0);
        end
        checkOutput({tag, ".sbEmpty"}, 144'(expQ.size()), 144'd0);
    endtask

    initial begin
        int hsStart;
        bit sawDone;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[5] = {12'd9, triRec(12'd5)};
        mem[9] = {12'd7, triRec(12'd9)};
        mem[7] = {12'd0, triRec(12'd7)};
        mem[4] = {12'd4, triRec(12'd4)};
        bus.listRegisters       = '0;
        bus.listRegisters[1][2] = 12'd5;
        bus.listRegisters[3][3] = 12'd4;
        bus.startWalk   = 1'b0;
        bus.binX        = '0;
        bus.binY        = '0;
        bus.doneBinning = 1'b1;
        bus.triReady    = 1'b1;

        #12;
        checkOutput("rst.triValid", 144'(bus.triValid), 144'd0);
        checkOutput("rst.binBusy", 144'(bus.binBusy), 144'd0);
        checkOutput("rst.triCount", 144'(bus.triCount), 144'd0);
        checkOutput("rst.readAddr", 144'(bus.binMemoryReadAddress), 144'd0);
        #5 RESET_N = 1'b1;
        nextCycle();

        // Empty bin
        applyStimulus(4'd2, 4'd3);
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) nextCycle();
            sample();
            checkOutput($sformatf("empty.triValid@%0d", c), 144'(bus.triValid), 144'd0);
            checkOutput($sformatf("empty.binDone@%0d", c), 144'(bus.binDone), 144'(c == 2));
            checkOutput($sformatf("empty.binBusy@%0d", c), 144'(bus.binBusy), 144'(c == 1));
            if (c == 2) checkOutput("empty.triCount", 144'(bus.triCount), 144'd0);
        end
        nextCycle();

        walkThree("three");
        nextCycle();

        // Backpressure on the second entry for ten cycles
        expQ.push_back(triRec(12'd5));
        expQ.push_back(triRec(12'd9));
        expQ.push_back(triRec(12'd7));
        applyStimulus(4'd1, 4'd2);
        for (int c = 1; c <= 22; c++) begin
            if (c > 1) nextCycle();
            bus.triReady = !(c >= 6 && c <= 15);
            sample();
            checkOutput($sformatf("bp.triValid@%0d", c), 144'(bus.triValid),
                        144'(c == 3 || (c >= 6 && c <= 16) || c == 19));
            checkOutput($sformatf("bp.binDone@%0d", c), 144'(bus.binDone), 144'(c == 21));
        end
        checkOutput("bp.triCount", 144'(bus.triCount), 144'd3);
        checkOutput("bp.sbEmpty", 144'(expQ.size()), 144'd0);
        bus.triReady = 1'b1;
        nextCycle();

        // Self-loop terminated by the loop guard
        for (int i = 0; i < 4095; i++) expQ.push_back(triRec(12'd4));
        hsStart = hsCount;
        applyStimulus(4'd3, 4'd3);
        sawDone = 1'b0;
        for (int n = 0; n < 15000 && !sawDone; n++) begin
            sample();
            if (bus.binDone) sawDone = 1'b1;
            else nextCycle();
        end
        checkOutput("loop.binDone", 144'(sawDone), 144'd1);
        checkOutput("loop.triCount", 144'(bus.triCount), 144'd4095);
        checkOutput("loop.walkError", 144'(bus.walkError), 144'd1);
        checkOutput("loop.handshakes", 144'(hsCount - hsStart), 144'd4095);
        checkOutput("loop.sbEmpty", 144'(expQ.size()), 144'd0);
        repeat (3) nextCycle();
        sample();
        checkOutput("loop.errorSticky", 144'(bus.walkError), 144'd1);
        nextCycle();

        // Abort during PRESENT of entry 2 while held off
        expQ.push_back(triRec(12'd5));
        applyStimulus(4'd1, 4'd2);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) nextCycle();
            if (c == 6) begin
                bus.triReady    = 1'b0;
                bus.doneBinning = 1'b0;
            end
            sample();
            if (c == 1) checkOutput("abort.errorCleared", 144'(bus.walkError), 144'd0);
            checkOutput($sformatf("abort.triValid@%0d", c), 144'(bus.triValid),
                        144'(c == 3 || c == 6));
            checkOutput($sformatf("abort.pulse@%0d", c), 144'(bus.walkAborted), 144'(c == 7));
            checkOutput($sformatf("abort.binDone@%0d", c), 144'(bus.binDone), 144'd0);
            if (c == 7) begin
                checkOutput("abort.triCount", 144'(bus.triCount), 144'd1);
                checkOutput("abort.binBusy", 144'(bus.binBusy), 144'd0);
            end
        end
        bus.doneBinning = 1'b1;
        bus.triReady    = 1'b1;
        checkOutput("abort.sbEmpty", 144'(expQ.size()), 144'd0);
        nextCycle();

        // Abort coinciding with a handshake
        expQ.push_back(triRec(12'd5));
        expQ.push_back(triRec(12'd9));
        applyStimulus(4'd1, 4'd2);
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) nextCycle();
            if (c == 6) bus.doneBinning = 1'b0;
            sample();
            checkOutput($sformatf("coin.pulse@%0d", c), 144'(bus.walkAborted), 144'(c == 7));
            checkOutput($sformatf("coin.binDone@%0d", c), 144'(bus.binDone), 144'd0);
            if (c == 7) checkOutput("coin.triCount", 144'(bus.triCount), 144'd2);
        end
        bus.doneBinning = 1'b1;
        checkOutput("coin.sbEmpty", 144'(expQ.size()), 144'd0);
        nextCycle();

        // Start ignored while binning is not finished
        bus.doneBinning = 1'b0;
        applyStimulus(4'd1, 4'd2);
        sample();
        checkOutput("ignore.binBusy", 144'(bus.binBusy), 144'd0);
        nextCycle();
        sample();
        checkOutput("ignore.triValid", 144'(bus.triValid), 144'd0);
        nextCycle();
        bus.doneBinning = 1'b1;

        // Asynchronous reset during READ
        applyStimulus(4'd1, 4'd2);
        #2 RESET_N = 1'b0;
        #1;
        checkOutput("arst.triValid", 144'(bus.triValid), 144'd0);
        checkOutput("arst.binBusy", 144'(bus.binBusy), 144'd0);
        checkOutput("arst.binDone", 144'(bus.binDone), 144'd0);
        checkOutput("arst.walkAborted", 144'(bus.walkAborted), 144'd0);
        checkOutput("arst.walkError", 144'(bus.walkError), 144'd0);
        checkOutput("arst.triCount", 144'(bus.triCount), 144'd0);
        checkOutput("arst.triData", 144'(bus.triData), 144'd0);
        checkOutput("arst.readAddr", 144'(bus.binMemoryReadAddress), 144'd0);
        repeat (2) nextCycle();
        @(negedge BOARD_CLK);
        RESET_N = 1'b1;
        nextCycle();
        sample();
        checkOutput("arst.noDonePulse", 144'(bus.binDone), 144'd0);
        checkOutput("arst.noAbortPulse", 144'(bus.walkAborted), 144'd0);
        nextCycle();
        walkThree("postRst");

        checkOutput("final.sbEmpty", 144'(expQ.size()), 144'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
